// File: rtl/boss_ctrl.sv
// Stage-3 boss controller: frame-ticked motion, walk animation, hit points and defeat.
// All outputs come straight from registers updated on the system clock.
module boss_ctrl #(
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 300,
  parameter int unsigned Y_HOME     = 20,
  parameter int unsigned SPEED      = 2,
  parameter int unsigned HP_INIT    = 10,
  parameter int unsigned HURT_TICKS = 8,
  parameter int unsigned FRAME_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       tick,
  input  logic       hit,
  output logic [8:0] boss_x,
  output logic [8:0] boss_y,
  output logic [3:0] boss_state,
  output logic [3:0] boss_hp,
  output logic       boss_dead
);

  localparam logic [3:0] Stage3    = 4'd6;
  localparam logic [8:0] XHome     = 9'((X_MIN + X_MAX) / 2);
  localparam logic [8:0] YHome     = 9'(Y_HOME);
  localparam logic [9:0] XMinW     = 10'(X_MIN);
  localparam logic [9:0] XMaxW     = 10'(X_MAX);
  localparam logic [9:0] SpeedW    = 10'(SPEED);
  localparam logic [3:0] HpInit    = 4'(HP_INIT);
  localparam logic [3:0] HurtTicks = 4'(HURT_TICKS);
  localparam logic [3:0] FrameDiv  = 4'(FRAME_DIV);

  typedef enum logic [1:0] {StIdle, StMove, StHurt, StDead} st_e;

  st_e        st_q, st_d;
  logic [8:0] x_q, x_d, y_q, y_d;
  logic [3:0] anim_q, anim_d, hp_q, hp_d;
  logic [3:0] tick_cnt_q, tick_cnt_d, frame_cnt_q, frame_cnt_d, hurt_cnt_q, hurt_cnt_d;
  logic       dir_q, dir_d;
  logic [9:0] x_wide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StIdle;
      x_q         <= XHome;
      y_q         <= YHome;
      anim_q      <= 4'd1;
      hp_q        <= HpInit;
      dir_q       <= 1'b0;
      tick_cnt_q  <= 4'd0;
      frame_cnt_q <= 4'd0;
      hurt_cnt_q  <= 4'd0;
    end else begin
      st_q        <= st_d;
      x_q         <= x_d;
      y_q         <= y_d;
      anim_q      <= anim_d;
      hp_q        <= hp_d;
      dir_q       <= dir_d;
      tick_cnt_q  <= tick_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      hurt_cnt_q  <= hurt_cnt_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    x_d         = x_q;
    y_d         = y_q;
    anim_d      = anim_q;
    hp_d        = hp_q;
    dir_d       = dir_q;
    tick_cnt_d  = tick_cnt_q;
    frame_cnt_d = frame_cnt_q;
    hurt_cnt_d  = hurt_cnt_q;
    x_wide      = {1'b0, x_q};

    // Leaving the stage dominates everything; IDLE keeps reloading home values.
    if (state != Stage3 || st_q == StIdle) begin
      st_d        = (state == Stage3) ? StMove : StIdle;
      x_d         = XHome;
      y_d         = YHome;
      anim_d      = 4'd1;
      hp_d        = HpInit;
      dir_d       = 1'b0;
      tick_cnt_d  = 4'd0;
      frame_cnt_d = 4'd0;
      hurt_cnt_d  = 4'd0;
    end else begin
      unique case (st_q)
        StMove: begin
          if (hit) begin
            if (hp_q <= 4'd1) begin
              hp_d   = 4'd0;
              st_d   = StDead;
              anim_d = 4'd6;
            end else begin
              hp_d       = hp_q - 4'd1;
              st_d       = StHurt;
              hurt_cnt_d = HurtTicks;
              anim_d     = 4'd5;
            end
          end else if (tick) begin
            // Bounds are tested in 10 bits so the edge clamp never wraps.
            if (!dir_q) begin
              if (x_wide + SpeedW >= XMaxW) begin
                x_d   = XMaxW[8:0];
                dir_d = 1'b1;
              end else begin
                x_d = 9'(x_wide + SpeedW);
              end
            end else begin
              if (x_wide <= XMinW + SpeedW) begin
                x_d   = XMinW[8:0];
                dir_d = 1'b0;
              end else begin
                x_d = 9'(x_wide - SpeedW);
              end
            end
            tick_cnt_d  = tick_cnt_q + 4'd1;
            y_d         = YHome + (tick_cnt_d[3] ? 9'd2 : 9'd0);
            frame_cnt_d = frame_cnt_q + 4'd1;
            if (frame_cnt_d >= FrameDiv) begin
              frame_cnt_d = 4'd0;
              anim_d      = (anim_q >= 4'd4) ? 4'd1 : anim_q + 4'd1;
            end
          end
        end
        StHurt: begin
          if (tick) begin
            hurt_cnt_d = hurt_cnt_q - 4'd1;
            if (hurt_cnt_q <= 4'd1) begin
              hurt_cnt_d  = 4'd0;
              st_d        = StMove;
              anim_d      = 4'd1;
              frame_cnt_d = 4'd0;
            end
          end
        end
        StDead: begin
        end
        default: st_d = StIdle;
      endcase
    end
  end

  always_comb begin
    boss_x     = x_q;
    boss_y     = y_q;
    boss_state = anim_q;
    boss_hp    = hp_q;
    boss_dead  = (st_q == StDead);
  end

endmodule

// File: tb/tb_boss_ctrl.sv
// Directed bench for boss_ctrl: the driver queues hand-derived expectations after each
// clocked step and an independent negedge monitor pops and compares them.
module tb_boss_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] state = 4'd0;
  logic       tick = 1'b0;
  logic       hit = 1'b0;
  logic [8:0] boss_x, boss_y;
  logic [3:0] boss_state, boss_hp;
  logic       boss_dead;

  always #5 clk = ~clk;

  boss_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .tick      (tick),
    .hit       (hit),
    .boss_x    (boss_x),
    .boss_y    (boss_y),
    .boss_state(boss_state),
    .boss_hp   (boss_hp),
    .boss_dead (boss_dead)
  );

  logic [26:0] exp_q[$];
  string       name_q[$];
  int          vectors = 0;
  int          misses = 0;
  logic [26:0] mon_exp, mon_act;
  string       mon_name;

  task automatic expect_out(input string nm, input int x, input int y, input int anim,
                            input int hp, input bit dead);
    logic [26:0] v;
    v = {9'(x), 9'(y), 4'(anim), 4'(hp), dead};
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic expect_home(input string nm);
    expect_out(nm, 150, 20, 1, 10, 1'b0);
  endtask

  // One clock step: inputs change at negedge, pulses drop just after the posedge.
  task automatic cyc(input logic [3:0] st, input logic tk, input logic ht);
    @(negedge clk);
    state = st;
    tick  = tk;
    hit   = ht;
    @(posedge clk);
    #1;
    tick = 1'b0;
    hit  = 1'b0;
  endtask

  // Eight ticks in HURT at a frozen position; the last one returns to MOVE.
  task automatic serve_hurt(input string nm, input int x, input int y, input int hp);
    for (int i = 1; i <= 8; i++) begin
      cyc(4'd6, 1'b1, 1'b0);
      expect_out(nm, x, y, (i == 8) ? 1 : 5, hp, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {boss_x, boss_y, boss_state, boss_hp, boss_dead};
      vectors++;
      if (mon_act !== mon_exp) begin
        misses++;
        $display("FAIL %s: got x=%0d y=%0d st=%0d hp=%0d dead=%0d, want x=%0d y=%0d st=%0d hp=%0d dead=%0d",
                 mon_name, mon_act[26:18], mon_act[17:9], mon_act[8:5], mon_act[4:1], mon_act[0],
                 mon_exp[26:18], mon_exp[17:9], mon_exp[8:5], mon_exp[4:1], mon_exp[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    // Power-on reset, then idle with ticks outside the stage.
    #1 rst_n = 1'b0;
    #1 expect_home("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(4'd0, 1'b1, 1'b0);
      expect_home("idle_por");
    end

    // Bounce to the right wall: 75 ticks reach 300, the 76th comes back to 298.
    cyc(4'd6, 1'b0, 1'b0);
    expect_home("enter_move");
    for (int n = 1; n <= 75; n++) begin
      cyc(4'd6, 1'b1, 1'b0);
      expect_out("bounce", 150 + 2 * n, ((n % 16) >= 8) ? 22 : 20, 1 + ((n / 4) % 4), 10, 1'b0);
    end
    cyc(4'd6, 1'b0, 1'b0);
    expect_out("no_tick_hold", 300, 22, 3, 10, 1'b0);
    cyc(4'd6, 1'b1, 1'b0);
    expect_out("bounce_back", 298, 22, 4, 10, 1'b0);

    // Asynchronous reset mid-run: home values before any clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 expect_home("async_reset");
    for (int i = 0; i < 2; i++) begin
      cyc(4'd6, 1'b1, 1'b0);
      expect_home("reset_held");
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(4'd0, 1'b1, 1'b0);
      expect_home("idle_after_reset");
    end

    // Walk to x=160, hit, then three more hits during HURT are ignored.
    cyc(4'd6, 1'b0, 1'b0);
    expect_home("enter_move2");
    for (int n = 1; n <= 5; n++) begin
      cyc(4'd6, 1'b1, 1'b0);
      expect_out("walk", 150 + 2 * n, 20, 1 + (n / 4), 10, 1'b0);
    end
    cyc(4'd6, 1'b0, 1'b1);
    expect_out("hit", 160, 20, 5, 9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(4'd6, 1'b1, 1'b1);
      expect_out("hurt_invuln", 160, 20, 5, 9, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(4'd6, 1'b1, 1'b0);
      expect_out("hurt_hold", 160, 20, 5, 9, 1'b0);
    end
    cyc(4'd6, 1'b1, 1'b0);
    expect_out("hurt_exit", 160, 20, 1, 9, 1'b0);
    cyc(4'd6, 1'b1, 1'b0);
    expect_out("move_resume", 162, 20, 1, 9, 1'b0);

    // Tick and hit together: the hit wins, no movement.
    cyc(4'd6, 1'b1, 1'b1);
    expect_out("tick_and_hit", 162, 20, 5, 8, 1'b0);
    serve_hurt("hurt2", 162, 20, 8);

    // Leave the stage while in HURT, then return.
    cyc(4'd6, 1'b0, 1'b1);
    expect_out("hit3", 162, 20, 5, 7, 1'b0);
    cyc(4'd8, 1'b0, 1'b0);
    expect_home("leave_stage");
    cyc(4'd8, 1'b1, 1'b1);
    expect_home("idle_off_stage");
    cyc(4'd6, 1'b0, 1'b0);
    expect_home("reenter_move");
    cyc(4'd6, 1'b1, 1'b0);
    expect_out("reenter_walk", 152, 20, 1, 10, 1'b0);

    // Defeat: ten spaced hits.
    for (int k = 1; k <= 9; k++) begin
      cyc(4'd6, 1'b0, 1'b1);
      expect_out("defeat_hit", 152, 20, 5, 10 - k, 1'b0);
      serve_hurt("defeat_hurt", 152, 20, 10 - k);
    end
    cyc(4'd6, 1'b0, 1'b1);
    expect_out("dead", 152, 20, 6, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(4'd6, 1'b1, 1'b1);
      expect_out("dead_frozen", 152, 20, 6, 0, 1'b1);
    end
    cyc(4'd6, 1'b1, 1'b0);
    expect_out("dead_tick", 152, 20, 6, 0, 1'b1);
    cyc(4'd0, 1'b0, 1'b0);
    expect_home("dead_leave");

    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      misses++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/boss_ctrl.md
# boss_ctrl

Per-frame motion, animation and hit-point controller for the stage-3 boss. Runs a small state machine clocked by the system clock and advanced by a one-cycle frame tick. It produces the registered boss position and animation-frame code that the boss sprite renderer consumes. It also produces the boss hit-point count and a defeat flag for the game-state logic.

## Interface
- X_MIN, 0, leftmost boss_x (sprite is 20×20 on the 320×240 half-res grid)
- X_MAX, 300, rightmost boss_x
- Y_HOME, 20, base boss_y
- SPEED, 2, horizontal pixels per tick
- HP_INIT, 10, starting hit points (1..15)
- HURT_TICKS, 8, ticks spent in HURT after a hit (1..15)
- FRAME_DIV, 4, ticks per animation frame step (1..15)

- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- state  in  4  game state; boss is active only when state == 6 (STAGE3)
- tick  in  1  one-cycle pulse, once per video frame
- hit  in  1  one-cycle pulse, player shot overlapped boss
- boss_x  out  9  sprite left edge, registered
- boss_y  out  9  sprite top edge, registered
- boss_state  out  4  animation frame code: 1–4 walk, 5 hurt, 6 dead
- boss_hp  out  4  remaining hit points
- boss_dead  out  1  high while in DEAD

## Operation
- States: IDLE, MOVE, HURT, DEAD. Internal registers:
  - dir (0 = right)
  - tick_cnt (4 bit, free-running on tick in MOVE)
  - frame_cnt (4 bit)
  - hurt_cnt (4 bit)
- Home values:
  - boss_x = (X_MIN+X_MAX)/2 = 150
  - boss_y = Y_HOME
  - boss_state = 1, boss_hp = HP_INIT, boss_dead = 0
  - dir = 0; all counters 0
- Reset (rst_n low, any time): state IDLE with home values, applied immediately.
- Top priority, all states: if state != STAGE3, go to IDLE next cycle and reload home values.
- IDLE: hold home values. If state == STAGE3, go to MOVE.
- MOVE, on tick with hit low:
  - Horizontal, dir = 0: if boss_x+SPEED >= X_MAX, boss_x = X_MAX and dir = 1; else boss_x += SPEED.
  - Horizontal, dir = 1: if boss_x <= X_MIN+SPEED, boss_x = X_MIN and dir = 0; else boss_x -= SPEED.
  - tick_cnt += 1 (wraps at 16).
  - boss_y = Y_HOME + (new tick_cnt[3] ? 2 : 0).
  - frame_cnt += 1. When it reaches FRAME_DIV, clear it and advance boss_state 1→2→3→4→1.
- MOVE, on hit:
  - boss_hp -= 1.
  - If boss_hp was 1: boss_hp = 0, go to DEAD, boss_state = 6, boss_dead = 1.
  - Otherwise: go to HURT, hurt_cnt = HURT_TICKS, boss_state = 5.
  - A tick in the same cycle is ignored (no move, no count).
- HURT:
  - boss_x and boss_y frozen; hit ignored (invulnerable).
  - Each tick: hurt_cnt -= 1. When hurt_cnt reaches 0, go to MOVE with boss_state = 1 and frame_cnt = 0.
  - dir and tick_cnt are preserved across HURT.
- DEAD: all outputs frozen, hit and tick ignored. Leaves only via the non-STAGE3 rule or reset.
- Widths: boss_x and boss_y are 9-bit unsigned. Bounds logic never wraps, so boss_x stays within [X_MIN, X_MAX] at all times. boss_hp never underflows.

## Timing
- Every output is a register. Each update is visible the cycle after the qualifying tick, hit or state edge (1-cycle latency).
- IDLE→MOVE takes 1 cycle after state becomes 6. The first motion occurs on the first tick seen in MOVE.
- A hit pulse is sampled only on the cycle it is high. It is never queued.
- Reset deassertion is synchronous-safe: the first edge after rst_n rises evaluates IDLE.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n = 0 mid-run, then release with state = 0 and several ticks.
  - Required: boss_x = 150, boss_y = 20, boss_state = 1, boss_hp = 10, boss_dead = 0, all held.
- Bounce:
  - Stimulus: state = 6 with 75 ticks.
  - Required: boss_x reaches 300 at tick 75 and dir flips. The next tick gives 298.
  - Required: boss_state cycles 1,2,3,4 every 4 ticks. boss_y toggles 20/22 every 8 ticks.
- Hit and HURT:
  - Stimulus: hit in MOVE at boss_x = 160, then hits on each of the next 3 ticks.
  - Required: boss_hp = 9 and boss_state = 5. boss_x holds at 160 for 8 ticks and the extra hits are ignored.
  - Required: the following cycle returns to MOVE with boss_state = 1.
- Defeat:
  - Stimulus: 10 spaced hits, each after HURT expires.
  - Required: after the 10th, boss_hp = 0, boss_dead = 1, boss_state = 6, and position is frozen under further ticks and hits.
- Simultaneous tick and hit:
  - Stimulus: assert both in the same cycle during MOVE.
  - Required: boss_hp decrements, boss_x unchanged, state goes to HURT.
- Leave stage mid-operation:
  - Stimulus: state goes 6→8 while in HURT, then back to 6.
  - Required: IDLE with home values one cycle after the 6→8 change. MOVE resumes with boss_hp = 10.
